io_line_sector: RTL

IO_LINE_SECTOR -- requirements
Module: io_line_sector

---
 rtl/io_sector_pkg.sv | 15 +
 rtl/io_sync_fifo.sv | 62 ++++++
 rtl/io_line_sector.sv | 118 +++++++++++
 3 files changed

// File: rtl/io_sector_pkg.sv
// Shared defaults and derived-width helper for the I/O line sector.
// Latency: n/a (constants and a compile-time function only).
// Backpressure: n/a.
package io_sector_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_CHANNELS = 2;
    localparam int DEF_DEPTH    = 4;

    // Channel tag width; a single channel still gets a one-bit tag so ports never collapse.
    function automatic int chWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous DEPTH-entry FIFO with occupancy count and combinational head.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: push refused while full (even with a simultaneous pop); pop ignored while empty.
module io_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign doPush  = push && !full;
    assign doPop   = pop && !empty;
    assign popData = mem[rdPtr];

    // Storage needs no reset: only entries between the pointers are ever observed.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers wrap explicitly at DEPTH-1; count tracks push/pop balance.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= (wrPtr == PTR_W'(DEPTH - 1)) ? '0 : wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= (rdPtr == PTR_W'(DEPTH - 1)) ? '0 : rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_line_sector.sv
// Core-facing I/O sector: queued output lines to an external sink, per-channel input holding registers.
// Latency: output word reaches the head one cycle after the write; input word readable one cycle after capture.
// Backpressure: stall when writing a full queue or reading an empty channel; sink/producers use valid/ready.
module io_line_sector
    import io_sector_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DEPTH    = DEF_DEPTH,
    localparam int CH_W    = chWidth(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      outWrite,
    input  logic [CH_W-1:0]           outChannel,
    input  logic [WIDTH-1:0]          outData,
    input  logic                      inRead,
    input  logic [CH_W-1:0]           inChannel,
    output logic [WIDTH-1:0]          inData,
    output logic                      stall,
    output logic [WIDTH-1:0]          outputLine,
    output logic [CH_W-1:0]           outputChannel,
    output logic                      outputValid,
    input  logic                      outputReady,
    input  logic [CHANNELS*WIDTH-1:0] inputLine,
    input  logic [CHANNELS-1:0]       inputValid,
    output logic [CHANNELS-1:0]       inputReady
);

    localparam int ENTRY_W = CH_W + WIDTH;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    // One bit wider than the tag so the range check is never trivially constant.
    localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

    logic               outOk;
    logic               inOk;
    logic               fifoPush;
    logic               fifoPop;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [CNT_W-1:0]   fifoCount;
    logic [ENTRY_W-1:0] fifoHead;

    logic [CHANNELS-1:0] held;
    logic [WIDTH-1:0]    holdData [CHANNELS];
    logic                heldSel;
    logic [WIDTH-1:0]    selData;

    // Out-of-range channel numbers act as no-ops on either side.
    assign outOk = ({1'b0, outChannel} < CH_LIMIT);
    assign inOk  = ({1'b0, inChannel}  < CH_LIMIT);

    assign fifoPush = outWrite && outOk;
    assign fifoPop  = outputValid && outputReady;

    io_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) uOutFifo (
        .clk      (clk),
        .resetN   (resetN),
        .push     (fifoPush),
        .pushData ({outChannel, outData}),
        .pop      (fifoPop),
        .popData  (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    assign outputValid   = (fifoCount != '0);
    assign outputLine    = fifoEmpty ? '0 : fifoHead[WIDTH-1:0];
    assign outputChannel = fifoEmpty ? '0 : fifoHead[ENTRY_W-1:WIDTH];

    for (genvar c = 0; c < CHANNELS; c++) begin : gHold
        logic             heldQ;
        logic [WIDTH-1:0] dataQ;
        logic             capture;
        logic             release_;

        assign capture  = inputValid[c] && !heldQ;
        assign release_ = inRead && inOk && (inChannel == CH_W'(c)) && heldQ;

        // Capture when empty, release when the core reads this channel; the two cannot coincide.
        always_ff @(posedge clk) begin
            if (!resetN) begin
                heldQ <= 1'b0;
            end else begin
                if (capture) begin
                    heldQ <= 1'b1;
                    dataQ <= inputLine[c*WIDTH +: WIDTH];
                end else if (release_) begin
                    heldQ <= 1'b0;
                end
            end
        end

        assign held[c]       = heldQ;
        assign holdData[c]   = dataQ;
        assign inputReady[c] = !heldQ;
    end

    // Select the addressed holding register; no match leaves both defaults at zero.
    always_comb begin
        heldSel = 1'b0;
        selData = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (inChannel == CH_W'(c)) begin
                heldSel = held[c];
                selData = holdData[c];
            end
        end
    end

    assign inData = (inRead && inOk && heldSel) ? selData : '0;
    assign stall  = (outWrite && outOk && fifoFull) || (inRead && inOk && !heldSel);

endmodule
